// File: rtl/module_keypad_scanner.sv
// rtl/module_keypad_scanner.sv - 4x4 keypad column scanner with debounce and valid/ack key handshake
// Define KEYPAD_HEX_MAP_EN to report keypad legend codes instead of raw 4*row+col indices.
module module_keypad_scanner #(
   parameter int SCAN_TICKS     = 27000,
   parameter int DEBOUNCE_TICKS = 270000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] rows,
   output logic [3:0] columns,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack
);
   localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_TICKS - 1);
   localparam logic [DW-1:0] DEB_FULL  = DW'(DEBOUNCE_TICKS);
   localparam logic [DW-1:0] REL_LAST  = DW'(DEBOUNCE_TICKS - 1);

   typedef enum logic [1:0] {SCAN, DEBOUNCE, WAIT_RELEASE} state_t;

   state_t        state_q, state_d;
   logic [3:0]    rows_m_q, rows_s_q;
   logic [1:0]    col_q, col_d;
   logic [3:0]    columns_q, columns_d;
   logic [SW-1:0] scan_cnt_q, scan_cnt_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic [3:0]    cand_q, cand_d;
   logic [1:0]    row_q, row_d;
   logic [3:0]    key_code_q, key_code_d;
   logic          key_valid_q, key_valid_d;
   logic          one_low;
   logic [1:0]    low_row;

   function automatic logic [3:0] code_of(input logic [1:0] r, input logic [1:0] c);
`ifdef KEYPAD_HEX_MAP_EN
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
      endcase
      return code;
`else
      return {r, c};
`endif
   endfunction

   // Only a single low row counts as a key; none or several are ignored.
   always_comb begin
      one_low = 1'b1;
      low_row = 2'd0;
      case (rows_s_q)
         4'b1110: low_row = 2'd0;
         4'b1101: low_row = 2'd1;
         4'b1011: low_row = 2'd2;
         4'b0111: low_row = 2'd3;
         default: one_low = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      scan_cnt_d  = scan_cnt_q;
      deb_cnt_d   = deb_cnt_q;
      cand_d      = cand_q;
      row_d       = row_q;
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q & ~key_ack;
      unique case (state_q)
         SCAN: begin
            if (scan_cnt_q == SCAN_LAST) begin
               scan_cnt_d = '0;
               if (one_low && !key_valid_q) begin
                  state_d   = DEBOUNCE;
                  cand_d    = rows_s_q;
                  row_d     = low_row;
                  deb_cnt_d = '0;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end else begin
               scan_cnt_d = scan_cnt_q + 1'b1;
            end
         end
         DEBOUNCE: begin
            if (deb_cnt_q == DEB_FULL) begin
               state_d     = WAIT_RELEASE;
               key_code_d  = code_of(row_q, col_q);
               key_valid_d = 1'b1;
               deb_cnt_d   = '0;
            end else if (rows_s_q != cand_q) begin
               state_d    = SCAN;
               col_d      = col_q + 2'd1;
               scan_cnt_d = '0;
               deb_cnt_d  = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
         WAIT_RELEASE: begin
            if (rows_s_q != 4'hF) begin
               deb_cnt_d = '0;
            end else if (deb_cnt_q == REL_LAST) begin
               state_d    = SCAN;
               col_d      = col_q + 2'd1;
               scan_cnt_d = '0;
               deb_cnt_d  = '0;
            end else begin
               deb_cnt_d = deb_cnt_q + 1'b1;
            end
         end
         default: state_d = SCAN;
      endcase
      columns_d = ~(4'b0001 << col_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SCAN;
         rows_m_q    <= 4'hF;
         rows_s_q    <= 4'hF;
         col_q       <= 2'd0;
         columns_q   <= 4'b1110;
         scan_cnt_q  <= '0;
         deb_cnt_q   <= '0;
         cand_q      <= 4'hF;
         row_q       <= 2'd0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_m_q    <= rows;
         rows_s_q    <= rows_m_q;
         col_q       <= col_d;
         columns_q   <= columns_d;
         scan_cnt_q  <= scan_cnt_d;
         deb_cnt_q   <= deb_cnt_d;
         cand_q      <= cand_d;
         row_q       <= row_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign columns   = columns_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
endmodule

// File: tb/tb_module_keypad_scanner.sv
// tb/tb_module_keypad_scanner.sv - directed bench for module_keypad_scanner with a 4x4 keypad model
module tb_module_keypad_scanner;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_ack = 1'b0;
   logic [3:0]  rows;
   logic [3:0]  columns;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [15:0] pressed = '0;
   logic        glitch = 1'b0;
   logic        mon_en = 1'b0;
   logic        prev_valid = 1'b0;
   logic [3:0]  cols_prev;
   logic [3:0]  rot [4];
   int          n_checks = 0;
   int          n_errors = 0;
   int          rises = 0;
   int          base;

`ifdef KEYPAD_HEX_MAP_EN
   localparam logic [3:0] K11 = 4'hC;
   localparam logic [3:0] K13 = 4'h0;
`else
   localparam logic [3:0] K11 = 4'hB;
   localparam logic [3:0] K13 = 4'hD;
`endif

   module_keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_TICKS(8)) dut (
      .clk(clk), .rst(rst), .rows(rows), .columns(columns),
      .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack)
   );

   always #5 clk = ~clk;

   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[4*r+c] && !columns[c] && !glitch) rows[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_valid(input int budget, input string tag);
      int k = 0;
      while (!key_valid && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, key_valid}, 32'd1);
   endtask

   task automatic ack_pulse();
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("one_col_low", $countones(~columns), 32'd1);
         if (key_valid && !prev_valid) rises++;
      end
      prev_valid = key_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;

      // reset and column rotation
      repeat (3) @(negedge clk);
      check("rst_columns", columns, 4'b1110);
      check("rst_valid", key_valid, 1'b0);
      check("rst_code", key_code, 4'h0);
      mon_en = 1'b1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         repeat (4) @(negedge clk);
         check("rotate", columns, rot[i]);
      end

      // clean press, hold without ack, ack, no re-report while held
      #1 base = rises;
      pressed[11] = 1'b1;
      wait_valid(100, "press_valid");
      check("press_code", key_code, K11);
      repeat (30) @(negedge clk);
      check("hold_valid", key_valid, 1'b1);
      check("hold_code", key_code, K11);
      ack_pulse();
      check("ack_clear", key_valid, 1'b0);
      repeat (40) @(negedge clk);
      #1 check("held_no_rereport", rises - base, 32'd1);

      // release and re-press reports again
      pressed = '0;
      repeat (30) @(negedge clk);
      pressed[11] = 1'b1;
      wait_valid(100, "repress_valid");
      check("repress_code", key_code, K11);
      #1 check("repress_count", rises - base, 32'd2);

      // another key while valid is pending is neither queued nor overwrites
      pressed = '0;
      repeat (30) @(negedge clk);
      pressed[0] = 1'b1;
      repeat (60) @(negedge clk);
      check("blocked_valid", key_valid, 1'b1);
      check("blocked_code", key_code, K11);
      pressed = '0;
      repeat (30) @(negedge clk);
      ack_pulse();
      check("blocked_ack_clear", key_valid, 1'b0);
      repeat (60) @(negedge clk);
      #1 check("nothing_queued", rises - base, 32'd2);

      // bouncing contact: glitch every 5 cycles, then stable
      base = rises;
      pressed[11] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         glitch = (i % 5 == 4);
         @(negedge clk);
      end
      glitch = 1'b0;
      #1 check("bounce_quiet", rises - base, 32'd0);
      check("bounce_valid_low", key_valid, 1'b0);
      @(negedge clk);
      wait_valid(80, "bounce_valid");
      check("bounce_code", key_code, K11);
      repeat (20) @(negedge clk);
      #1 check("bounce_once", rises - base, 32'd1);
      pressed = '0;
      repeat (30) @(negedge clk);
      ack_pulse();

      // two rows low on column 0 is no key
      base = rises;
      pressed[4] = 1'b1;
      pressed[8] = 1'b1;
      repeat (60) @(negedge clk);
      check("dual_valid", key_valid, 1'b0);
      cols_prev = columns;
      repeat (4) @(negedge clk);
      check("dual_scanning", {31'd0, cols_prev != columns}, 32'd1);
      #1 check("dual_quiet", rises - base, 32'd0);
      pressed = '0;
      @(negedge clk);

      // reset at debounce count 5 aborts, later press reports
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pressed[0] = 1'b1;
      #1 base = rises;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_columns", columns, 4'b1110);
      check("midrst_valid", key_valid, 1'b0);
      check("midrst_code", key_code, 4'h0);
      rst = 1'b0;
      pressed = '0;
      repeat (10) @(negedge clk);
      #1 check("midrst_no_report", rises - base, 32'd0);
      pressed[13] = 1'b1;
      @(negedge clk);
      wait_valid(100, "post_rst_valid");
      check("post_rst_code", key_code, K13);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/module_keypad_scanner.md
MODULE_KEYPAD_SCANNER -- requirements
Module: module_keypad_scanner

Interface
REQ-001 Parameter SCAN_TICKS, default 27000: clock cycles each column strobe is held in SCAN (1 ms at 27 MHz).
REQ-002 Parameter DEBOUNCE_TICKS, default 270000: consecutive stable cycles required for press or release (10 ms at 27 MHz).
REQ-003 clk  input  1  system clock, 27 MHz; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rows  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 columns  output  4  column strobes, active-low; exactly one bit SHALL be 0 at all times.
REQ-007 key_code  output  4  code of the last debounced key.
REQ-008 key_valid  output  1  key_code holds an unacknowledged key.
REQ-009 key_ack  input  1  consumer acknowledge; the key is consumed when key_ack=1 and key_valid=1 in the same cycle.

Function
REQ-010 rows SHALL pass through a 2-flop synchronizer (rows_s); all decisions SHALL use rows_s only.
REQ-011 FSM states SHALL be SCAN, DEBOUNCE and WAIT_RELEASE.
REQ-012 SCAN: column index c cycles 0->1->2->3->0 with columns = ~(1<<c); index advances after SCAN_TICKS cycles.
REQ-013 SCAN: rows_s is sampled in the last dwell cycle; exactly one bit low (row r) and key_valid=0 -> DEBOUNCE with candidate (r,c) and columns frozen; otherwise advance column.
REQ-014 Zero rows low or two or more rows low SHALL be treated as no key.
REQ-015 DEBOUNCE: counter increments each cycle rows_s equals the candidate pattern; any mismatch -> SCAN at column c+1 with no report.
REQ-016 On the counter reaching DEBOUNCE_TICKS, the next edge SHALL load key_code, set key_valid=1 and enter WAIT_RELEASE.
REQ-017 WAIT_RELEASE: columns frozen; rows_s=4'b1111 for DEBOUNCE_TICKS consecutive cycles -> SCAN at column c+1; any low row restarts the count.
REQ-018 key_valid SHALL clear on the edge following a consume and stay 1 until then, in any state.
REQ-019 A consume coinciding with a REQ-016 load SHALL leave key_valid=1 with the new code.
REQ-020 While key_valid=1, no new key SHALL be detected (REQ-013); nothing SHALL be queued or overwritten.
REQ-021 key_code SHALL remain stable while key_valid=1.
REQ-022 Counters SHALL be sized with $clog2 of their parameters and SHALL never wrap.

Reset
REQ-023 rst=1 SHALL, on the next edge, force state SCAN, c=0, columns=4'b1110, key_code=4'h0, key_valid=0, counters=0, synchronizer flops=4'b1111.
REQ-024 rst asserted mid-DEBOUNCE or mid-WAIT_RELEASE SHALL abort the operation with no key reported.

Configuration
REQ-025 Macro KEYPAD_HEX_MAP_EN defined: key_code SHALL follow the keypad legend, row0 1,2,3,A; row1 4,5,6,B; row2 7,8,9,C; row3 E(*),0,F(#),D.
REQ-026 Macro KEYPAD_HEX_MAP_EN undefined: key_code SHALL be the raw index 4*r+c.

Verification (bench overrides SCAN_TICKS=4, DEBOUNCE_TICKS=8; keypad model drives rows from columns)
REQ-027 Hold rst 3 cycles -> columns=4'b1110, key_valid=0, key_code=0; columns then rotate 1101, 1011, 0111 every 4 cycles.
REQ-028 Clean press row2/col3, held >20 cycles -> one key_valid with key_code=4'hB raw, 4'hC with KEYPAD_HEX_MAP_EN.
REQ-029 Bounce row2/col3 with glitches every 5 cycles, then stable -> no key_valid during bouncing; exactly one key_valid after 8 stable cycles.
REQ-030 key_ack held 0 for 30 cycles -> key_valid and key_code hold; ack pulse -> key_valid=0 next cycle; no second report until release plus re-press.
REQ-031 Rows 1 and 2 low together on column 0 -> key_valid stays 0 and scanning continues.
REQ-032 rst pulse at debounce count 5 -> reset values next cycle, no key_valid; a later clean press reports normally.
